// File: rtl/sm_node_encoder.sv
`default_nettype none
// ============================================================================
// Module   : sm_node_encoder
// Brief    : Debounced, minimum-width node level built from three line-sensor
//            ADC samples, with a rise pulse, black/white mask and node tally.
// Option   : define NODE_HYST_EN to release against TH_WHITE in ON/DRAIN.
// Revision : 1.0 - initial release
// ============================================================================
module sm_node_encoder #(
  parameter int unsigned ADC_W    = 12,
  parameter int unsigned TH_BLACK = 2000,
  parameter int unsigned TH_WHITE = 1800,
  parameter int unsigned ON_CNT   = 4,
  parameter int unsigned OFF_CNT  = 4,
  parameter int unsigned MIN_HOLD = 200002
) (
  input  logic             clk_50,
  input  logic             reset,
  input  logic             sample_valid,
  input  logic [ADC_W-1:0] adc_l,
  input  logic [ADC_W-1:0] adc_c,
  input  logic [ADC_W-1:0] adc_r,
  output logic             node_detected,
  output logic             node_rise,
  output logic [2:0]       black_mask,
  output logic [7:0]       node_total
);

  localparam int unsigned c_HOLD_W = $clog2(MIN_HOLD + 1);
  localparam int unsigned c_RUN_W  = $clog2(ON_CNT + 1);
  localparam int unsigned c_OFF_W  = $clog2(OFF_CNT + 1);

  localparam logic [ADC_W-1:0]    c_TH_BLACK  = ADC_W'(TH_BLACK);
  localparam logic [c_RUN_W-1:0]  c_ON_LAST   = c_RUN_W'(ON_CNT);
  localparam logic [c_OFF_W-1:0]  c_OFF_LAST  = c_OFF_W'(OFF_CNT);
  localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(MIN_HOLD - 1);

  localparam logic [1:0] c_ST_OFF   = 2'd0;
  localparam logic [1:0] c_ST_ARM   = 2'd1;
  localparam logic [1:0] c_ST_ON    = 2'd2;
  localparam logic [1:0] c_ST_DRAIN = 2'd3;

  // Elaboration-time sanity checks on the configuration.
  if (TH_WHITE > TH_BLACK) begin : g_chk_th
    $error("sm_node_encoder: TH_WHITE must not exceed TH_BLACK");
  end
  if (ON_CNT < 1 || OFF_CNT < 1 || MIN_HOLD < 1) begin : g_chk_cnt
    $error("sm_node_encoder: ON_CNT, OFF_CNT and MIN_HOLD must be at least 1");
  end

  logic [1:0]          r_state;
  logic [c_RUN_W-1:0]  r_run_cnt;
  logic [c_OFF_W-1:0]  r_off_cnt;
  logic [c_HOLD_W-1:0] r_hold_cnt;
  logic                r_node_detected;
  logic                r_node_rise;
  logic [2:0]          r_black_mask;
  logic [7:0]          r_node_total;

  logic [1:0]          w_state_nxt;
  logic [c_RUN_W-1:0]  w_run_nxt;
  logic [c_OFF_W-1:0]  w_off_nxt;
  logic [c_HOLD_W-1:0] w_hold_nxt;
  logic [c_RUN_W-1:0]  w_run_inc;
  logic [c_OFF_W-1:0]  w_off_inc;
  logic [ADC_W-1:0]    w_th;
  logic [2:0]          w_black;
  logic                w_all_black;
  logic                w_enter_on;
  logic                w_det_nxt;
  logic [2:0]          w_mask_nxt;
  logic [7:0]          w_total_nxt;

`ifdef NODE_HYST_EN
  localparam logic [ADC_W-1:0] c_TH_WHITE = ADC_W'(TH_WHITE);
  // Once a node is up, a lower threshold holds it against marginal samples.
  assign w_th = (r_state == c_ST_ON || r_state == c_ST_DRAIN) ? c_TH_WHITE : c_TH_BLACK;
`else
  assign w_th = c_TH_BLACK;
`endif

  assign w_black     = {adc_l > w_th, adc_c > w_th, adc_r > w_th};
  assign w_all_black = &w_black;
  assign w_run_inc   = r_run_cnt + c_RUN_W'(1);
  assign w_off_inc   = r_off_cnt + c_OFF_W'(1);

  // State register
  always_ff @(posedge clk_50) begin
    if (reset) begin
      r_state         <= c_ST_OFF;
      r_run_cnt       <= '0;
      r_off_cnt       <= '0;
      r_hold_cnt      <= '0;
      r_node_detected <= 1'b0;
      r_node_rise     <= 1'b0;
      r_black_mask    <= 3'b000;
      r_node_total    <= 8'd0;
    end else begin
      r_state         <= w_state_nxt;
      r_run_cnt       <= w_run_nxt;
      r_off_cnt       <= w_off_nxt;
      r_hold_cnt      <= w_hold_nxt;
      r_node_detected <= w_det_nxt;
      r_node_rise     <= w_enter_on;
      r_black_mask    <= w_mask_nxt;
      r_node_total    <= w_total_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_run_nxt   = r_run_cnt;
    w_off_nxt   = r_off_cnt;
    w_hold_nxt  = r_hold_cnt;
    case (r_state)
      // OFF and ARM share the qualifying path: run_cnt is 0 in OFF.
      c_ST_OFF, c_ST_ARM: begin
        if (sample_valid) begin
          if (w_all_black) begin
            if (w_run_inc == c_ON_LAST) begin
              w_state_nxt = c_ST_ON;
              w_run_nxt   = '0;
              w_hold_nxt  = '0;
            end else begin
              w_state_nxt = c_ST_ARM;
              w_run_nxt   = w_run_inc;
            end
          end else begin
            w_state_nxt = c_ST_OFF;
            w_run_nxt   = '0;
          end
        end
      end
      c_ST_ON: begin
        if (r_hold_cnt == c_HOLD_LAST) begin
          w_state_nxt = c_ST_DRAIN;
          w_off_nxt   = '0;
        end else begin
          w_hold_nxt  = r_hold_cnt + c_HOLD_W'(1);
        end
      end
      c_ST_DRAIN: begin
        if (sample_valid) begin
          if (w_all_black) begin
            w_off_nxt = '0;
          end else if (w_off_inc == c_OFF_LAST) begin
            w_state_nxt = c_ST_OFF;
            w_off_nxt   = '0;
            w_run_nxt   = '0;
          end else begin
            w_off_nxt = w_off_inc;
          end
        end
      end
      default: begin
        w_state_nxt = c_ST_OFF;
        w_run_nxt   = '0;
        w_off_nxt   = '0;
        w_hold_nxt  = '0;
      end
    endcase
  end

  // Output logic, registered in the state register process
  always_comb begin
    w_enter_on  = (w_state_nxt == c_ST_ON) && (r_state != c_ST_ON);
    w_det_nxt   = (w_state_nxt == c_ST_ON) || (w_state_nxt == c_ST_DRAIN);
    w_mask_nxt  = sample_valid ? w_black : r_black_mask;
    w_total_nxt = r_node_total;
    if (w_enter_on && (r_node_total != 8'hFF)) begin
      w_total_nxt = r_node_total + 8'd1;
    end
  end

  assign node_detected = r_node_detected;
  assign node_rise     = r_node_rise;
  assign black_mask    = r_black_mask;
  assign node_total    = r_node_total;

endmodule
`default_nettype wire

// File: tb/tb_sm_node_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sm_node_encoder
// Brief    : Directed self-checking bench for sm_node_encoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sm_node_encoder;

  logic        clk_50 = 1'b0;
  logic        reset;
  logic        sample_valid;
  logic [11:0] adc_l, adc_c, adc_r;
  logic        node_detected, node_rise;
  logic [2:0]  black_mask;
  logic [7:0]  node_total;

  int n_tests = 0;
  int n_fail  = 0;

  always #10 clk_50 = ~clk_50;

  sm_node_encoder #(
    .ADC_W(12), .TH_BLACK(2000), .TH_WHITE(1800),
    .ON_CNT(4), .OFF_CNT(4), .MIN_HOLD(20)
  ) u_dut (
    .clk_50(clk_50), .reset(reset), .sample_valid(sample_valid),
    .adc_l(adc_l), .adc_c(adc_c), .adc_r(adc_r),
    .node_detected(node_detected), .node_rise(node_rise),
    .black_mask(black_mask), .node_total(node_total)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_50);
      #1;
    end
  endtask

  task automatic send(input logic [11:0] l, input logic [11:0] c, input logic [11:0] r);
    adc_l = l; adc_c = c; adc_r = r;
    sample_valid = 1'b1;
    step(1);
    sample_valid = 1'b0;
  endtask

  // n strobes of the same value, one every 5 clocks; returns right after the last
  task automatic send_run(input logic [11:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      if (i > 0) step(4);
      send(v, v, v);
    end
  endtask

  initial begin
    int exp_total;
    reset = 1'b1; sample_valid = 1'b0;
    adc_l = '0; adc_c = '0; adc_r = '0;
    step(2);
    check_eq("rst_det",   32'(node_detected), 0);
    check_eq("rst_rise",  32'(node_rise), 0);
    check_eq("rst_mask",  32'(black_mask), 0);
    check_eq("rst_total", 32'(node_total), 0);
    reset = 1'b0;
    step(1);

    // Glitch: centre sample exactly at TH_BLACK is not black
    send_run(12'd3000, 3);
    step(4);
    send(12'd3000, 12'd2000, 12'd3000);
    check_eq("glitch_mask", 32'(black_mask), 3'b101);
    check_eq("glitch_det",  32'(node_detected), 0);
    step(4);
    send_run(12'd3000, 3);
    check_eq("glitch_det2",  32'(node_detected), 0);
    check_eq("glitch_total", 32'(node_total), 0);
    step(4);
    send(12'd500, 12'd500, 12'd500);
    step(4);

    // Basic node; white strobe on the ON->DRAIN cycle must be ignored
    send_run(12'd3000, 3);
    check_eq("arm_det", 32'(node_detected), 0);
    step(4);
    send(12'd3000, 12'd3000, 12'd3000);
    check_eq("on_det",   32'(node_detected), 1);
    check_eq("on_rise",  32'(node_rise), 1);
    check_eq("on_total", 32'(node_total), 1);
    check_eq("on_mask",  32'(black_mask), 3'b111);
    step(1);
    check_eq("rise_1cyc", 32'(node_rise), 0);
    check_eq("on_hold",   32'(node_detected), 1);
    step(18);
    send(12'd500, 12'd500, 12'd500);
    step(4);
    send_run(12'd500, 3);
    check_eq("drain_ignore", 32'(node_detected), 1);
    check_eq("drain_mask",   32'(black_mask), 0);
    step(4);
    send(12'd500, 12'd500, 12'd500);
    check_eq("release", 32'(node_detected), 0);

    // DRAIN interrupted by a black sample restarts the release count
    step(4);
    send_run(12'd3000, 4);
    check_eq("int_total", 32'(node_total), 2);
    step(20);
    send(12'd500, 12'd500, 12'd500);
    step(4);
    send(12'd500, 12'd500, 12'd500);
    step(4);
    send(12'd3000, 12'd3000, 12'd3000);
    step(4);
    send_run(12'd500, 3);
    check_eq("int_hold", 32'(node_detected), 1);
    step(4);
    send(12'd500, 12'd500, 12'd500);
    check_eq("int_release", 32'(node_detected), 0);

    // Saturation of the tally across 256 nodes in total
    for (int k = 0; k < 254; k++) begin
      step(4);
      send_run(12'd3000, 4);
      exp_total = (k + 3 > 255) ? 255 : k + 3;
      check_eq("sat_rise",  32'(node_rise), 1);
      check_eq("sat_total", 32'(node_total), 32'(exp_total));
      step(20);
      send_run(12'd500, 4);
    end
    check_eq("sat_det", 32'(node_detected), 0);

    // Reset during ON wins over a simultaneous black strobe
    step(4);
    send_run(12'd3000, 4);
    check_eq("pre_rst_det",   32'(node_detected), 1);
    check_eq("pre_rst_total", 32'(node_total), 255);
    step(10);
    reset = 1'b1;
    send(12'd3000, 12'd3000, 12'd3000);
    reset = 1'b0;
    check_eq("mid_rst_det",   32'(node_detected), 0);
    check_eq("mid_rst_rise",  32'(node_rise), 0);
    check_eq("mid_rst_mask",  32'(black_mask), 0);
    check_eq("mid_rst_total", 32'(node_total), 0);
    step(4);
    send_run(12'd3000, 3);
    check_eq("post_rst_arm", 32'(node_detected), 0);
    step(4);
    send(12'd3000, 12'd3000, 12'd3000);
    check_eq("post_rst_det",   32'(node_detected), 1);
    check_eq("post_rst_rise",  32'(node_rise), 1);
    check_eq("post_rst_total", 32'(node_total), 1);

    // Samples between the two thresholds while the node is up
    step(20);
    send_run(12'd1900, 4);
`ifdef NODE_HYST_EN
    check_eq("hyst_hold", 32'(node_detected), 1);
    check_eq("hyst_mask", 32'(black_mask), 3'b111);
    step(4);
    send_run(12'd1700, 4);
    check_eq("hyst_release", 32'(node_detected), 0);
    check_eq("hyst_mask2",   32'(black_mask), 0);
`else
    check_eq("nohyst_release", 32'(node_detected), 0);
    check_eq("nohyst_mask",    32'(black_mask), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
